// File: rtl/wb_ram_slave.sv
// wb_ram_slave: word-addressed RAM slave with address window decode, programmable wait states and single-cycle ack
module wb_ram_slave #(
  parameter int ADDR_W = 10,
  parameter int WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        W_RST,
  input  logic        W_STB,
  input  logic        W_WE,
  input  logic [3:0]  W_SEL,
  input  logic [31:0] W_ADDR,
  input  logic [31:0] W_DAT_I,
  output logic [31:0] W_DAT_O,
  output logic        W_ACK
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t state, state_d;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] idx_q, idx_c;
  logic we_q, we_c, go, commit;
  logic [3:0] sel_q;
  logic [31:0] dat_q;
  logic [31:0] mem [2**ADDR_W];
  always_comb begin
    go = W_STB && (((W_ADDR ^ BASE_ADDR) >> (ADDR_W + 2)) == 32'd0);
    idx_c = state == IDLE ? W_ADDR[ADDR_W+1:2] : idx_q;
    we_c = state == IDLE ? W_WE : we_q;
    commit = state == IDLE ? go && WS == 4'd0 : state == WAIT && W_STB && cnt == 4'd1;
    state_d = state == IDLE ? (go ? (WS == 4'd0 ? ACK : WAIT) : IDLE) :
              state == WAIT ? (!W_STB ? IDLE : cnt == 4'd1 ? ACK : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge W_RST)
    if (!W_RST) begin
      state <= IDLE;
      cnt <= 4'd0;
      W_ACK <= 1'b0;
      W_DAT_O <= 32'h0;
      idx_q <= '0;
      we_q <= 1'b0;
      sel_q <= 4'h0;
      dat_q <= 32'h0;
    end else begin
      state <= state_d;
      W_ACK <= commit;
      if (state == IDLE && go) begin
        cnt <= WS;
        idx_q <= idx_c;
        we_q <= W_WE;
        sel_q <= W_SEL;
        dat_q <= W_DAT_I;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (commit && !we_c) W_DAT_O <= mem[idx_c];
    end
  always_ff @(posedge clk)
    if (state == ACK && we_q)
      for (int i = 0; i < 4; i++)
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: randomized self-checking bench for wb_ram_slave against a word-array reference model
module tb_wb_ram_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic stb [3];
  logic we [3];
  logic ack [3];
  logic [3:0] sel [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic [31:0] mdl [3][1024];
  int ws [3] = '{1, 3, 0};
  int checks = 0;
  int fails = 0;

  wb_ram_slave u0 (.clk(clk), .W_RST(rst_n), .W_STB(stb[0]), .W_WE(we[0]), .W_SEL(sel[0]),
    .W_ADDR(addr[0]), .W_DAT_I(wdat[0]), .W_DAT_O(rdat[0]), .W_ACK(ack[0]));
  wb_ram_slave #(.WAIT_STATES(3), .BASE_ADDR(32'h1000_0000)) u1 (.clk(clk), .W_RST(rst_n),
    .W_STB(stb[1]), .W_WE(we[1]), .W_SEL(sel[1]), .W_ADDR(addr[1]), .W_DAT_I(wdat[1]),
    .W_DAT_O(rdat[1]), .W_ACK(ack[1]));
  wb_ram_slave #(.WAIT_STATES(0)) u2 (.clk(clk), .W_RST(rst_n), .W_STB(stb[2]), .W_WE(we[2]),
    .W_SEL(sel[2]), .W_ADDR(addr[2]), .W_DAT_I(wdat[2]), .W_DAT_O(rdat[2]), .W_ACK(ack[2]));

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  task automatic xfer(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output bit acked, output int lat, output logic [31:0] rd);
    @(negedge clk);
    stb[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wdat[k] = d;
    acked = 1'b0; lat = -1; rd = 32'h0;
    for (int n = 0; n < 20 && !acked; n++) begin
      @(posedge clk); #1;
      if (ack[k]) begin acked = 1'b1; lat = n; rd = rdat[k]; end
    end
    @(negedge clk);
    stb[k] = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stb[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0; addr[k] = 32'h0; wdat[k] = 32'h0;
    end
    stb[0] = 1'b1; addr[0] = 32'h40; sel[0] = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack[0] !== 1'b0) begin fails++; $display("FAIL rst_ack got=%b exp=0", ack[0]); end
    checks++; if (rdat[0] !== 32'h0) begin fails++; $display("FAIL rst_dat got=%h exp=0", rdat[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (ack[0]) break;
    end
    checks++; if (n != ws[0] + 1) begin fails++; $display("FAIL rst_first_ack got=%0d exp=%0d", n, ws[0] + 1); end
    @(negedge clk);
    stb[0] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write_read;
    bit a; int l; logic [31:0] r;
    xfer(0, 1'b1, 4'hF, 32'h10, 32'hCAFEBABE, a, l, r);
    mdl[0][4] = 32'hCAFEBABE;
    checks++; if (!a || l != ws[0]) begin fails++; $display("FAIL wr_lat acked=%0d got=%0d exp=%0d", a, l, ws[0]); end
    @(posedge clk); #1;
    checks++; if (ack[0] !== 1'b0) begin fails++; $display("FAIL ack_pulse got=%b exp=0", ack[0]); end
    xfer(0, 1'b0, 4'h0, 32'h10, 32'h0, a, l, r);
    checks++; if (!a || l != ws[0] || r !== mdl[0][4]) begin fails++; $display("FAIL rd_10 acked=%0d lat=%0d got=%h exp=%h", a, l, r, mdl[0][4]); end
    xfer(0, 1'b0, 4'h0, 32'h12, 32'h0, a, l, r);
    checks++; if (!a || r !== mdl[0][4]) begin fails++; $display("FAIL rd_12 acked=%0d got=%h exp=%h", a, r, mdl[0][4]); end
  endtask

  task automatic test_byte_en;
    bit a; int l; logic [31:0] r;
    xfer(0, 1'b1, 4'hF, 32'h20, 32'h11223344, a, l, r);
    mdl[0][8] = 32'h11223344;
    xfer(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, a, l, r);
    mdl[0][8] = merge(mdl[0][8], 32'hAABBCCDD, 4'b0101);
    xfer(0, 1'b0, 4'h0, 32'h20, 32'h0, a, l, r);
    checks++; if (!a || r !== mdl[0][8]) begin fails++; $display("FAIL byte_en acked=%0d got=%h exp=%h", a, r, mdl[0][8]); end
    xfer(0, 1'b1, 4'b0000, 32'h20, 32'h12345678, a, l, r);
    checks++; if (!a || l != ws[0]) begin fails++; $display("FAIL sel0_ack acked=%0d lat=%0d", a, l); end
    xfer(0, 1'b0, 4'h0, 32'h20, 32'h0, a, l, r);
    checks++; if (!a || r !== mdl[0][8]) begin fails++; $display("FAIL sel0_data got=%h exp=%h", r, mdl[0][8]); end
  endtask

  task automatic test_window;
    bit a; int l; logic [31:0] r, d0, d1;
    d0 = $urandom; d1 = $urandom;
    xfer(1, 1'b1, 4'hF, 32'h1000_0FFC, d1, a, l, r);
    mdl[1][1023] = d1;
    checks++; if (!a || l != ws[1]) begin fails++; $display("FAIL win_top_wr acked=%0d lat=%0d exp=%0d", a, l, ws[1]); end
    xfer(1, 1'b0, 4'h0, 32'h1000_0FFC, 32'h0, a, l, r);
    checks++; if (!a || r !== mdl[1][1023]) begin fails++; $display("FAIL win_top_rd acked=%0d got=%h exp=%h", a, r, mdl[1][1023]); end
    xfer(1, 1'b1, 4'hF, 32'h1000_0000, d0, a, l, r);
    mdl[1][0] = d0;
    xfer(1, 1'b1, 4'hF, 32'h1000_1000, ~d0, a, l, r);
    checks++; if (a) begin fails++; $display("FAIL win_miss_hi acked=1 exp=0"); end
    xfer(1, 1'b0, 4'h0, 32'h0FFF_FFFC, 32'h0, a, l, r);
    checks++; if (a) begin fails++; $display("FAIL win_miss_lo acked=1 exp=0"); end
    xfer(1, 1'b0, 4'h0, 32'h1000_0000, 32'h0, a, l, r);
    checks++; if (!a || r !== mdl[1][0]) begin fails++; $display("FAIL win_word0 got=%h exp=%h", r, mdl[1][0]); end
  endtask

  task automatic test_abort;
    bit a, seen; int l; logic [31:0] r;
    xfer(1, 1'b1, 4'hF, 32'h1000_0014, $urandom | 32'h1, a, l, r);
    mdl[1][5] = wdat[1];
    @(negedge clk);
    stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; addr[1] = 32'h1000_0014; wdat[1] = ~mdl[1][5];
    @(posedge clk); @(posedge clk); #1;
    seen = ack[1];
    @(negedge clk);
    stb[1] = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= ack[1]; end
    checks++; if (seen) begin fails++; $display("FAIL abort_ack got=1 exp=0"); end
    xfer(1, 1'b0, 4'h0, 32'h1000_0014, 32'h0, a, l, r);
    checks++; if (!a || r !== mdl[1][5]) begin fails++; $display("FAIL abort_data got=%h exp=%h", r, mdl[1][5]); end
    @(negedge clk);
    stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; addr[1] = 32'h1000_0014; wdat[1] = 32'h5A5A_5A5A ^ mdl[1][5];
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (ack[1] !== 1'b0 || rdat[1] !== 32'h0) begin fails++; $display("FAIL rst_mid ack=%b dat=%h exp ack=0 dat=0", ack[1], rdat[1]); end
    stb[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 4'h0, 32'h1000_0014, 32'h0, a, l, r);
    checks++; if (!a || r !== mdl[1][5]) begin fails++; $display("FAIL rst_discard got=%h exp=%h", r, mdl[1][5]); end
  endtask

  task automatic test_back_to_back;
    bit a, got; int l, n; logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      xfer(2, 1'b1, 4'hF, 32'h40 + 32'(4 * i), $urandom, a, l, r);
      mdl[2][16 + i] = wdat[2];
    end
    checks++; if (!a || l != ws[2]) begin fails++; $display("FAIL b2b_wr_lat acked=%0d got=%0d exp=%0d", a, l, ws[2]); end
    @(negedge clk);
    stb[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
        @(posedge clk); #1; n++;
        if (ack[2]) got = 1'b1;
      end
      checks++;
      if (!got || n != (i == 0 ? 1 : 2) || rdat[2] !== mdl[2][16 + i]) begin
        fails++; $display("FAIL b2b_%0d acked=%0d gap=%0d got=%h exp=%h", i, got, n, rdat[2], mdl[2][16 + i]);
      end
      @(negedge clk);
      if (i < 3) addr[2] = 32'h40 + 32'(4 * (i + 1));
      else stb[2] = 1'b0;
    end
  endtask

  task automatic test_random;
    bit a; int l, op, idx; logic [31:0] r, ad, d, last;
    logic [3:0] s;
    bit known [1024];
    last = 32'h0;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      idx = 64 + $urandom_range(0, 31);
      d = $urandom;
      if (op == 0) begin
        ad = $urandom;
        if (ad[31:12] == 20'h0) ad[31] = 1'b1;
        xfer(0, 1'($urandom_range(0, 1)), 4'hF, ad, d, a, l, r);
        checks++; if (a || rdat[0] !== last) begin fails++; $display("FAIL rnd_miss acked=%0d dat=%h exp=%h", a, rdat[0], last); end
      end else if (op == 2 && known[idx]) begin
        xfer(0, 1'b0, 4'h0, 32'(idx * 4) | 32'($urandom_range(0, 3)), 32'h0, a, l, r);
        checks++; if (!a || l != ws[0] || r !== mdl[0][idx]) begin fails++; $display("FAIL rnd_rd idx=%0d lat=%0d got=%h exp=%h", idx, l, r, mdl[0][idx]); end
        last = mdl[0][idx];
      end else begin
        s = known[idx] ? 4'($urandom) : 4'hF;
        xfer(0, 1'b1, s, 32'(idx * 4), d, a, l, r);
        mdl[0][idx] = merge(known[idx] ? mdl[0][idx] : 32'h0, d, s);
        known[idx] = 1'b1;
        checks++; if (!a || l != ws[0] || rdat[0] !== last) begin fails++; $display("FAIL rnd_wr idx=%0d acked=%0d lat=%0d dat=%h exp=%h", idx, a, l, rdat[0], last); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_write_read;
    test_byte_en;
    test_window;
    test_abort;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

- Word-addressed on-chip RAM slave on the CPU system bus: the downstream stage that serves CPU instruction fetches, operand loads and stores.
- Decodes its address window, inserts a programmable number of wait states, then commits the write or returns read data with a single-cycle `W_ACK`.
- Sits between the bus and the memory array.
- Other slaves share the bus; unselected accesses are ignored.

## Interface

- `ADDR_W`, 10: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `WAIT_STATES`, 1: extra cycles between request capture and `W_ACK`; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: window base; aligned to 2^(ADDR_W+2) bytes.

Ports:

- `clk`, in, 1: single clock; all state updates on its rising edge.
- `W_RST`, in, 1: reset. Asynchronous and active-low: asserting it (low) immediately resets all state; release is synchronous to `clk`.
- `W_STB`, in, 1: request valid; the master holds it high until it sees `W_ACK`.
- `W_WE`, in, 1: 1 = write, 0 = read; sampled with `W_STB`.
- `W_SEL`, in, 4: byte enables for writes; bit i covers byte i (bits 8i+7:8i). Ignored on reads.
- `W_ADDR`, in, 32: byte address; bits 1:0 ignored.
- `W_DAT_I`, in, 32: write data from the master.
- `W_DAT_O`, out, 32: read data to the master.
- `W_ACK`, out, 1: transfer complete; a one-cycle pulse.

## Operation

- **hit** = `W_ADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]`.
- **Word index** = `W_ADDR[ADDR_W+1:2]`.
- **FSM states:** IDLE, WAIT, ACK.
- **IDLE:**
  - If `W_STB` && hit at the edge, latch index, `W_WE`, `W_SEL` and `W_DAT_I`, and load the counter with `WAIT_STATES`.
  - Go to WAIT if `WAIT_STATES` > 0, else to ACK.
  - A miss or `W_STB` = 0 stays in IDLE. No `W_ACK` on a miss, ever.
- **WAIT:**
  - Decrement the counter each edge.
  - When the counter reaches 1 (i.e. the next value is 0), go to ACK.
  - If `W_STB` is low at any WAIT edge: abort to IDLE, no write, no ack, `W_DAT_O` unchanged.
- **Entry into ACK (the commit edge):**
  - Write: each array byte whose latched `W_SEL` bit is 1 takes the latched data byte; other bytes keep their value. `W_SEL` = 4'b0000 completes with ack but no change.
  - Read: `W_DAT_O` gets array[index].
  - `W_ACK` goes to 1.
- **ACK:**
  - `W_ACK` = 1 for exactly this cycle; next edge returns to IDLE and clears `W_ACK`.
  - `W_STB` is not sampled in ACK.
  - A master that keeps `W_STB` high after the ack starts a new transaction, sampled in the following IDLE cycle (back-to-back allowed).
- **`W_DAT_O`:**
  - Holds the last read value until the next read commit.
  - Writes and aborts do not change it.
- **Read-after-write:** a read of a just-written word returns the new data, because transactions are serialised.
- **Reset (`W_RST` = 0):**
  - State = IDLE, counter = 0, `W_ACK` = 0, `W_DAT_O` = 32'h0.
  - Array contents are not reset (undefined at power-up).
  - Reset asserted before the commit edge discards the pending write.
- The wrap-around case does not exist: the index is truncated to `ADDR_W` bits only after the window check.

## Timing

- Let edge E be the IDLE edge where `W_STB` && hit is sampled.
- `W_ACK` is high during the cycle following edge E + `WAIT_STATES`:
  - `WAIT_STATES` = 0: ack in the cycle right after E.
  - `WAIT_STATES` = 1: ack one cycle later.
- Read data is valid in the same cycle as `W_ACK`.
- A write is visible to any read captured after the commit edge.
- **Throughput:** one transfer per `WAIT_STATES` + 2 cycles with back-to-back `W_STB`.
- **Outputs:** `W_ACK` and `W_DAT_O` are registered with no combinational path from inputs.
- **Request inputs:** only sampled at IDLE edges (`W_STB` also at WAIT edges for abort). Changes at other times have no effect.

## Test plan

- **Reset:** hold `W_RST` = 0 for 3 cycles with `W_STB` = 1 -> `W_ACK` = 0, `W_DAT_O` = 0. Release -> the first ack arrives exactly `WAIT_STATES` + 1 cycles after the first IDLE capture.
- **Write then read, default params:**
  - Write 32'hCAFEBABE to byte address 0x10 with `W_SEL` = 4'hF -> ack 2 cycles after capture.
  - Read 0x10 -> `W_DAT_O` = 32'hCAFEBABE in the ack cycle.
  - Read 0x12 -> same word.
- **Byte enables:**
  - Preload 32'h11223344 at 0x20.
  - Write 32'hAABBCCDD with `W_SEL` = 4'b0101 -> a read returns 32'h11BB33DD.
  - `W_SEL` = 0 -> acked, word unchanged.
- **Window/miss:** `BASE_ADDR` = 32'h1000_0000, `ADDR_W` = 10.
  - Read 0x1000_0FFC -> acked.
  - Access 0x1000_1000 with `W_STB` held 20 cycles -> no ack, and a write there does not alter word 0.
- **Abort and reset mid-operation:** `WAIT_STATES` = 3.
  - Drop `W_STB` in the 2nd WAIT cycle of a write -> no ack, word unchanged.
  - Assert `W_RST` in WAIT -> `W_ACK` = 0 immediately, write discarded.
- **Back-to-back:** `WAIT_STATES` = 0, hold `W_STB` for 4 reads of consecutive addresses -> acks every 2nd cycle with the correct data in each ack cycle.
